btn_event_ctrl: RTL
===================

Name: btn_event_ctrl

Overview:
Shared-resource debounce controller for a bank of mechanical push buttons. One sample-tick counter is time-shared by NUM_BTNS per-button stability counters. The block produces clean debounced levels and queues press/release events. A round-robin arbiter serialises the events onto one valid/ready stream for the downstream UI/FSM logic.

Parameters:
NUM_BTNS, 4, number of button inputs (2..16)
TICK_PERIOD, 6250000, i_clk cycles per sample tick (>=2)
STABLE_TICKS, 4, consecutive ticks a changed input must hold before the level flips (>=1)
IDX_W, $clog2(NUM_BTNS), derived localparam, event index width

Ports:
i_clk  in  1  system clock
i_rst  in  1  reset, asynchronous, active-high
i_btn  in  NUM_BTNS  raw asynchronous button inputs
i_evt_ready  in  1  consumer accepts event this cycle
o_btn_level  out  NUM_BTNS  debounced level per button
o_evt_valid  out  1  event present on o_evt_idx/o_evt_press
o_evt_idx  out  IDX_W  button index of event
o_evt_press  out  1  1=press (0->1), 0=release (1->0)
o_tick  out  1  one-cycle sample strobe (debug/visibility)
o_drop  out  1  sticky: an event was lost; cleared only by reset

Behaviour:
- Reset (async assert, sync release): tick count 0, synchronisers 0, levels 0, stability counters 0, pending bits 0, RR pointer 0, o_evt_valid 0, o_evt_idx 0, o_evt_press 0, o_tick 0, o_drop 0.
- Tick: counter runs 0..TICK_PERIOD-1. o_tick is 1 for exactly the cycle count==TICK_PERIOD-1, then wraps to 0. The period is exactly TICK_PERIOD cycles.
- Sync: each i_btn passes through a 2-flop synchroniser (sync[i]). Inputs are sampled only on o_tick cycles.
- Stability, per button, on a tick cycle:
  - If sync[i]==level[i], cnt[i]<=0.
  - Otherwise, if cnt[i]==STABLE_TICKS-1: level[i] flips, cnt[i]<=0, and the matching pending bit is set (press_p[i] if the new level is 1, rel_p[i] if 0).
  - Otherwise cnt[i]++.
  - Consequence: a glitch shorter than STABLE_TICKS ticks never changes the level.
- Overflow: a flip whose pending bit is already set, and is not cleared by a grant in the same cycle, sets o_drop. The pending bit stays 1. Set-and-grant in the same cycle: set wins and no drop.
- Arbiter, output slot register:
  - The slot is free when !o_evt_valid, or when o_evt_valid && i_evt_ready.
  - When free and any pending bit is set, load the first button with a pending bit, searching from RR pointer upward with wrap. Clear the granted bit and set RR pointer <= idx+1 (mod NUM_BTNS).
  - If one button has both press_p and rel_p set: when level==0, grant the press first; when level==1, grant the release first (preserves true order).
  - When free and nothing is pending, o_evt_valid <= 0.
  - Rule: o_evt_valid, idx and press hold stable while valid && !ready.
- Latency: level changes at the edge ending the tick cycle. Pending is set at the same edge. o_evt_valid rises 1 cycle later if the slot is free.
- Throughput: one event per cycle with ready held high.

Decomposition:
- Package btn_evt_pkg: typedef btn_evt_t {idx, press}; function clog2-safe IDX_W helper; constant SYNC_STAGES=2.
- One sub-module, sample_tick_gen: parameter TICK_PERIOD, ports i_clk, i_rst, o_tick. This is a pulse generator, not a derived clock, and everything stays on i_clk.
- Stability counters and the arbiter stay in the top module, generate-looped.

Test Plan (bench params NUM_BTNS=4, TICK_PERIOD=4, STABLE_TICKS=3):
- Clean press: hold i_btn[2]=1 for 20 cycles, ready=1 -> o_btn_level[2] rises after 3 ticks (<=12+3 cycles). Exactly one event {idx=2, press=1}. Release gives one {2,0}. o_drop=0.
- Glitch reject: pulse i_btn[1] high for 2 ticks (8 cycles) -> o_btn_level stays 0, no event.
- Simultaneous + round robin: i_btn=4'b1011 in one cycle, ready=1, pointer 0 -> events idx 0, 1, 3 on consecutive cycles. Then a second burst with pointer=0 after idx3 grant -> order restarts at 0.
- Backpressure: ready=0 while button 0 is pressed and later button 3 is pressed -> {0,1} held stable. Raise ready -> {0,1} then {3,1} on the next cycle.
- Ordering/overflow: ready=0, press then release button 2 -> both pending, level 0. Ready=1 -> {2,1} then {2,0}. A second press+release on button 2 while ready=0 sets o_drop=1.
- Async reset mid-stream: assert i_rst between clock edges while o_evt_valid=1 -> all outputs 0 immediately. After release, no stale events appear.

Source files
------------

// File: rtl/btn_evt_pkg.sv
// rtl/btn_evt_pkg.sv - shared types and helpers for the button event controller
package btn_evt_pkg;

  localparam int SYNC_STAGES = 2;
  localparam int MAX_IDX_W   = 4;

  typedef struct packed {
    logic [MAX_IDX_W-1:0] idx;
    logic                 press;
  } btn_evt_t;

  // Index width that never collapses to zero bits.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// rtl/sample_tick_gen.sv - one-cycle sample strobe every TICK_PERIOD clocks
module sample_tick_gen #(
  parameter int TICK_PERIOD = 6250000
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_tick
);

  localparam int CW = $clog2(TICK_PERIOD);

  logic [CW-1:0] cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt <= '0;
    end else if (o_tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign o_tick = (cnt == CW'(TICK_PERIOD - 1));

endmodule

// File: rtl/btn_event_ctrl.sv
// rtl/btn_event_ctrl.sv - debounced button levels with round-robin press/release event stream
module btn_event_ctrl
  import btn_evt_pkg::*;
#(
  parameter  int NUM_BTNS     = 4,
  parameter  int TICK_PERIOD  = 6250000,
  parameter  int STABLE_TICKS = 4,
  localparam int IDX_W        = idx_width(NUM_BTNS)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [NUM_BTNS-1:0] i_btn,
  input  logic                i_evt_ready,
  output logic [NUM_BTNS-1:0] o_btn_level,
  output logic                o_evt_valid,
  output logic [IDX_W-1:0]    o_evt_idx,
  output logic                o_evt_press,
  output logic                o_tick,
  output logic                o_drop
);

  localparam int CNT_W = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;

  logic                                 tick;
  logic [SYNC_STAGES-1:0][NUM_BTNS-1:0] sync_pipe;
  logic [NUM_BTNS-1:0]                  sync;
  logic [NUM_BTNS-1:0]                  level;
  logic [NUM_BTNS-1:0]                  flip;
  logic [NUM_BTNS-1:0]                  press_p, rel_p, pend;
  logic [NUM_BTNS-1:0]                  set_press, set_rel;
  logic [NUM_BTNS-1:0]                  gnt_mask, gnt_press_mask, gnt_rel_mask;
  logic [IDX_W-1:0]                     rr_ptr, gnt_idx, rr_next;
  logic [IDX_W:0]                       scan_idx;
  logic                                 gnt_found, gnt_press, slot_free, grant;
  logic                                 evt_valid, drop;
  btn_evt_t                             evt_q;
  logic                                 unused_evt_bits;

  sample_tick_gen #(.TICK_PERIOD(TICK_PERIOD)) u_tick (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .o_tick(tick)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync_pipe <= '0;
    end else begin
      sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], i_btn};
    end
  end

  assign sync = sync_pipe[SYNC_STAGES-1];

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
    logic [CNT_W-1:0] cnt;

    assign flip[i] = tick && (sync[i] != level[i]) && (cnt == CNT_W'(STABLE_TICKS - 1));

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        cnt <= '0;
      end else if (tick) begin
        if ((sync[i] == level[i]) || flip[i]) begin
          cnt <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

  // A flip raises the pending bit matching the new level.
  assign set_press = flip & ~level;
  assign set_rel   = flip & level;
  assign pend      = press_p | rel_p;
  assign slot_free = !evt_valid || i_evt_ready;

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan_idx  = '0;
    for (int k = 0; k < NUM_BTNS; k++) begin
      scan_idx = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (scan_idx >= (IDX_W+1)'(NUM_BTNS)) begin
        scan_idx = scan_idx - (IDX_W+1)'(NUM_BTNS);
      end
      if (!gnt_found && pend[scan_idx[IDX_W-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan_idx[IDX_W-1:0];
      end
    end
  end

  // With both edges pending, the current level tells which happened first.
  assign gnt_press      = press_p[gnt_idx] && (!rel_p[gnt_idx] || !level[gnt_idx]);
  assign grant          = slot_free && gnt_found;
  assign gnt_mask       = grant ? (NUM_BTNS'(1) << gnt_idx) : '0;
  assign gnt_press_mask = gnt_press ? gnt_mask : '0;
  assign gnt_rel_mask   = gnt_press ? '0 : gnt_mask;
  assign rr_next        = (gnt_idx == IDX_W'(NUM_BTNS - 1)) ? '0 : gnt_idx + IDX_W'(1);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      level   <= '0;
      press_p <= '0;
      rel_p   <= '0;
      drop    <= 1'b0;
    end else begin
      level   <= level ^ flip;
      press_p <= (press_p & ~gnt_press_mask) | set_press;
      rel_p   <= (rel_p & ~gnt_rel_mask) | set_rel;
      if (|(set_press & press_p & ~gnt_press_mask) || |(set_rel & rel_p & ~gnt_rel_mask)) begin
        drop <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      evt_valid <= 1'b0;
      evt_q     <= '0;
      rr_ptr    <= '0;
    end else if (slot_free) begin
      evt_valid <= gnt_found;
      if (gnt_found) begin
        evt_q.idx   <= MAX_IDX_W'(gnt_idx);
        evt_q.press <= gnt_press;
        rr_ptr      <= rr_next;
      end
    end
  end

  assign unused_evt_bits = ^evt_q.idx;

  assign o_btn_level = level;
  assign o_evt_valid = evt_valid;
  assign o_evt_idx   = evt_q.idx[IDX_W-1:0];
  assign o_evt_press = evt_q.press;
  assign o_tick      = tick;
  assign o_drop      = drop;

endmodule
